// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : E-stage multiply/divide sequencer with the HI/LO register pair,
//            mfhi/mflo read path and D-stage stall request.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        d_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] c_mult_cnt = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_div_cnt  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    localparam logic [3:0] c_op_mult  = 4'b0001;
    localparam logic [3:0] c_op_multu = 4'b0010;
    localparam logic [3:0] c_op_div   = 4'b0011;
    localparam logic [3:0] c_op_divu  = 4'b0100;
    localparam logic [3:0] c_op_mtlo  = 4'b0101;
    localparam logic [3:0] c_op_mthi  = 4'b0110;
    localparam logic [3:0] c_op_mflo  = 4'b0111;
    localparam logic [3:0] c_op_mfhi  = 4'b1000;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_mul_sx;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_product;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_divisor;
    logic [31:0] w_uquot;
    logic [31:0] w_urem;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Product truncated to 64 bits is exact for both signednesses once the
    // operands are extended to 64 bits the right way.
    always_comb begin
        w_is_mul  = (md_op == c_op_mult) || (md_op == c_op_multu);
        w_is_div  = (md_op == c_op_div)  || (md_op == c_op_divu);
        w_mul_sx  = (md_op == c_op_mult);
        w_mul_a   = {{32{w_mul_sx & A[31]}}, A};
        w_mul_b   = {{32{w_mul_sx & B[31]}}, B};
        w_product = w_mul_a * w_mul_b;
    end

    // Signed division via magnitudes: avoids the INT_MIN / -1 corner and gives
    // truncation toward zero with the remainder following the dividend.
    always_comb begin
        w_a_neg   = (md_op == c_op_div) & A[31];
        w_b_neg   = (md_op == c_op_div) & B[31];
        w_abs_a   = w_a_neg ? (32'd0 - A) : A;
        w_abs_b   = w_b_neg ? (32'd0 - B) : B;
        w_divisor = (B == 32'd0) ? 32'd1 : w_abs_b;
        w_uquot   = w_abs_a / w_divisor;
        w_urem    = w_abs_a % w_divisor;
        w_quot    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uquot) : w_uquot;
        w_rem     = w_a_neg ? (32'd0 - w_urem) : w_urem;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            S_IDLE: begin
                if (md_op == c_op_mtlo) lo_d = A;
                if (md_op == c_op_mthi) hi_d = A;
                if (start && (w_is_mul || w_is_div)) begin
                    state_d   = S_RUN;
                    count_d   = w_is_mul ? c_mult_cnt : c_div_cnt;
                    pend_hi_d = w_is_mul ? w_product[63:32] : w_rem;
                    pend_lo_d = w_is_mul ? w_product[31:0]  : w_quot;
                    pend_wr_d = w_is_mul || (B != 32'd0);
                end
            end
            S_RUN: begin
                count_d = count_q - c_one;
                if (count_q == c_one) begin
                    state_d = S_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    always_comb begin
        busy     = (state_q == S_RUN);
        md_stall = d_is_md & (start | busy);
        hi       = hi_q;
        lo       = lo_q;
        case (md_op)
            c_op_mflo: md_out = lo_q;
            c_op_mfhi: md_out = hi_q;
            default:   md_out = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Self-checking bench for muldiv_unit: directed corner cases plus
//            randomized traffic against a behavioural HI/LO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        d_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
        .d_is_md(d_is_md), .busy(busy), .md_stall(md_stall), .md_out(md_out),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining busy cycles plus the result the op will commit.
    int              m_rem;
    logic [31:0]     m_hi, m_lo, p_hi, p_lo;
    bit              p_wr;
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uprod, uq, ur;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem = 0; m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_wr = 0;
        end else if (m_rem > 0) begin
            if (m_rem == 1 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
            m_rem = m_rem - 1;
        end else begin
            if (md_op == 4'd5) m_lo = A;
            if (md_op == 4'd6) m_hi = A;
            if (start && md_op >= 4'd1 && md_op <= 4'd4) begin
                sa = $signed(A); sb = $signed(B);
                ua = A; ub = B;
                p_wr = 1;
                case (md_op)
                    4'd1: begin sq = sa * sb; p_hi = sq[63:32]; p_lo = sq[31:0]; end
                    4'd2: begin uprod = ua * ub; p_hi = uprod[63:32]; p_lo = uprod[31:0]; end
                    4'd3: begin
                        if (B == 0) p_wr = 0;
                        else begin sq = sa / sb; sr = sa % sb; p_lo = sq[31:0]; p_hi = sr[31:0]; end
                    end
                    default: begin
                        if (B == 0) p_wr = 0;
                        else begin uq = ua / ub; ur = ua % ub; p_lo = uq[31:0]; p_hi = ur[31:0]; end
                    end
                endcase
                m_rem = (md_op <= 4'd2) ? MC : DC;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic compare();
        logic [31:0] e_out;
        e_out = (md_op == 4'd7) ? m_lo : (md_op == 4'd8) ? m_hi : 32'd0;
        chk("busy", 32'(busy), 32'(m_rem > 0));
        chk("md_stall", 32'(md_stall), 32'(d_is_md & (start | (m_rem > 0))));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("md_out", md_out, e_out);
    endtask

    // Compare on the falling edge, then return just after the next rising edge.
    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_n);
        int n;
        start = 1'b1; md_op = op; A = a; B = b;
        step();
        start = 1'b0; md_op = 4'd0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            step();
        end
        chk("busy_len", 32'(n), 32'(exp_n));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 4'd0; A = 0; B = 0; d_is_md = 1'b0;
        step();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        step();

        // mult with stall observation
        d_is_md = 1'b1; start = 1'b1; md_op = 4'd1; A = 32'hFFFFFFFF; B = 32'd2;
        #1;
        chk("stall_on_start", 32'(md_stall), 32'h1);
        do_op(4'd1, 32'hFFFFFFFF, 32'd2, MC);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);
        chk("stall_fall", 32'(md_stall), 32'h0);
        md_op = 4'd8;
        #1;
        chk("mfhi_first_idle", md_out, 32'hFFFFFFFF);
        d_is_md = 1'b0;
        step();

        do_op(4'd2, 32'hFFFFFFFF, 32'd2, MC);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        do_op(4'd3, 32'hFFFFFFF9, 32'd2, DC);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        do_op(4'd4, 32'd7, 32'd2, DC);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        md_op = 4'd6; A = 32'h11; step();
        md_op = 4'd5; A = 32'h22; step();
        md_op = 4'd0;
        do_op(4'd4, 32'd5, 32'd0, DC);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, DC);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h0);

        // mthi ignored while busy, honoured when idle
        start = 1'b1; md_op = 4'd1; A = 32'd3; B = 32'd4;
        step();
        start = 1'b0; md_op = 4'd6; A = 32'hDEAD;
        step();
        chk("mthi_busy_hi", hi, 32'h0);
        md_op = 4'd0;
        for (int i = 0; i < 50 && busy === 1'b1; i++) step();
        chk("mult34_lo", lo, 32'd12);
        chk("mult34_hi", hi, 32'h0);
        md_op = 4'd6; A = 32'hDEAD;
        step();
        chk("mthi_idle_hi", hi, 32'hDEAD);
        md_op = 4'd8;
        #1;
        chk("mfhi_dead", md_out, 32'hDEAD);

        // reset aborts an in-flight op
        start = 1'b1; md_op = 4'd1; A = 32'd5; B = 32'd7;
        step();
        start = 1'b0; md_op = 4'd0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("no_late_lo", lo, 32'h0);
        md_op = 4'd8;
        #1;
        chk("abort_mfhi", md_out, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 9) < 4);
            md_op = start ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
            A = $urandom;
            if ($urandom_range(0, 9) == 0) A = 32'h80000000;
            case ($urandom_range(0, 7))
                0:       B = 32'd0;
                1:       B = 32'hFFFFFFFF;
                2:       B = 32'($urandom_range(1, 9));
                default: B = $urandom;
            endcase
            d_is_md = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0; md_op = 4'd0; d_is_md = 1'b0;
        for (int i = 0; i < 12; i++) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with its sequencer and HI/LO register pair, located in the E stage of the 5-stage MIPS pipeline.
- The pipeline controller supplies `start` and the 4-bit `md_op` code. This unit sequences the multi-cycle operation and owns HI/LO.
- It returns mfhi/mflo read data to the E-stage result mux.
- It produces the D-stage stall request used while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy duration for mult/multu (>=1)
DIV_CYCLES, 10, busy duration for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  E-stage instruction is mult/multu/div/divu (one-cycle pulse per instruction)
md_op  input  4  0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mtlo, 0110 mthi, 0111 mflo, 1000 mfhi, others none
A  input  32  forwarded rs value (E stage)
B  input  32  forwarded rt value (E stage)
d_is_md  input  1  D-stage instruction is any of the eight md_op instructions
busy  output  1  operation in flight
md_stall  output  1  D-stage stall request
md_out  output  32  HI for mfhi, LO for mflo, else 0
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset forces: busy=0, count=0, hi=0, lo=0, latched operands and results=0, state=IDLE. Consequently md_stall=0 and md_out=0.
- Reset asserted mid-operation aborts the operation. HI/LO are not written.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, count>0.
- IDLE, start=1 with md_op in {0001..0100} at edge t:
  - Latch the result into pending registers at edge t.
  - mult: signed 64-bit A*B.
  - multu: unsigned 64-bit A*B.
  - div: signed quotient to LO, signed remainder to HI. Truncate toward zero; remainder takes the sign of the dividend.
  - divu: unsigned equivalents.
  - count <= MULT_CYCLES or DIV_CYCLES; state <= RUN; busy=1 from t.
- RUN, each edge: count <= count-1.
- RUN, edge where count==1:
  - mult/multu: hi <= product[63:32], lo <= product[31:0].
  - div/divu: hi <= remainder, lo <= quotient.
  - state <= IDLE, busy <= 0.
  - busy is therefore high for exactly N cycles after the start edge. New HI/LO are visible in the first cycle busy=0.
- Division by zero (B==0 for div/divu): the unit still runs DIV_CYCLES, but hi/lo are left unchanged at completion.
- Signed overflow case div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while RUN: ignored; the in-flight operation continues. md_stall is designed to prevent this case.
- mtlo/mthi:
  - In IDLE, write A into lo/hi at the next edge. Takes effect the next cycle.
  - In RUN, ignored.
- mflo/mfhi: md_out is combinational from the current lo/hi. It never reflects the pending result.
- md_stall = d_is_md & (start | busy). This is combinational, so a back-to-back md instruction in D stalls in the same cycle start is seen.
- md_out = 0 for any md_op other than 0111/1000, including reserved codes.
- md_op values other than 0001..0100 with start=1: treated as no-op; state unchanged.
- All arithmetic is on 32-bit operands. The 64-bit product uses correct sign or zero extension.

Test Plan:
- Reset during op: start mult at t, assert reset at t+2 → busy=0, hi=lo=0; after release, mfhi returns 0 and no late write-back occurs.
- Mult timing: A=0xFFFFFFFF, B=2, mult → busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu → hi=0x00000001, lo=0xFFFFFFFE.
- Divide: div A=-7 (0xFFFFFFF9), B=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=2 → lo=3, hi=1.
- Divide by zero and overflow:
  - Preload hi=0x11, lo=0x22 via mthi/mtlo, then divu B=0 → after 10 cycles hi=0x11, lo=0x22.
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Stall behaviour:
  - d_is_md=1 while start=1, and during each busy cycle → md_stall=1; md_stall falls in the cycle busy falls.
  - mfhi issued in that first idle cycle returns the new HI.
  - d_is_md=0 during busy → md_stall=0.
- Ignored writes: mthi with A=0xDEAD while busy → hi unchanged; the same mthi in IDLE → hi=0xDEAD the next cycle, and mfhi md_out=0xDEAD.
